// File: rtl/aoc4_pkg.sv
// aoc4_pkg: constants and types shared by the day-4 grid loader
// and the prune machines that consume the grid bank.
package aoc4_pkg;

   localparam int AOC4_TX_WIDTH        = 32;
   localparam int AOC4_GRID_WIDTH      = 160;
   localparam int AOC4_BANK_ADDR_WIDTH = 8;
   localparam int AOC4_COL_ADDR_WIDTH  = 8;
   localparam int AOC4_WORDS_PER_ROW   = AOC4_GRID_WIDTH / AOC4_TX_WIDTH;

   localparam logic [7:0]  CH_AT    = 8'h40;
   localparam logic [7:0]  CH_DOT   = 8'h2E;
   localparam logic [7:0]  CH_LF    = 8'h0A;
   localparam logic [7:0]  CH_CR    = 8'h0D;
   localparam logic [15:0] ROLL_MAX = 16'hFFFF;

   typedef enum logic [2:0] {
      LD_IDLE,
      LD_FILL,
      LD_WRITE,
      LD_PAD,
      LD_DONE,
      LD_ERR
   } ld_state_t;

endpackage

// File: rtl/aoc4_word_packer.sv
// aoc4_word_packer: accumulates decoded cells into one bank word,
// tracking the in-word bit index and flagging the completing cell.
module aoc4_word_packer
   import aoc4_pkg::*;
#(
   parameter int TX_WIDTH = AOC4_TX_WIDTH
)(
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_clear,
   input  logic                i_push,
   input  logic                i_bit,
   input  logic                i_flush,
   output logic [TX_WIDTH-1:0] o_word,
   output logic                o_empty,
   output logic                o_word_full
);

   localparam int IW = $clog2(TX_WIDTH);
   localparam logic [IW-1:0] LAST_IDX = IW'(TX_WIDTH - 1);

   logic [TX_WIDTH-1:0] r_acc;
   logic [IW-1:0]       r_idx;
   logic                w_full;

   assign w_full      = i_push && (r_idx == LAST_IDX);
   assign o_word_full = w_full;
   assign o_word      = r_acc;
   assign o_empty     = (r_idx == '0);

   // Row start skips bit 0 (zero guard); a completed word is held until flushed.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_acc <= '0;
         r_idx <= '0;
      end else if (i_clear) begin
         r_acc <= '0;
         r_idx <= IW'(1);
      end else if (i_flush) begin
         r_acc <= '0;
      end else if (i_push) begin
         r_acc[r_idx] <= i_bit;
         r_idx        <= w_full ? '0 : r_idx + IW'(1);
      end
   end

endmodule

// File: rtl/aoc4_grid_loader.sv
// aoc4_grid_loader: ASCII grid stream to padded bank rows.
// AOC4_LOADER_COUNT_EN builds the saturating roll counter.
module aoc4_grid_loader
   import aoc4_pkg::*;
#(
   parameter int TX_WIDTH        = AOC4_TX_WIDTH,
   parameter int GRID_WIDTH      = AOC4_GRID_WIDTH,
   parameter int BANK_ADDR_WIDTH = AOC4_BANK_ADDR_WIDTH,
   parameter int COL_ADDR_WIDTH  = AOC4_COL_ADDR_WIDTH
)(
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       start_in,
   input  logic                       char_valid_in,
   input  logic [7:0]                 char_in,
   input  logic                       eof_in,
   output logic                       char_ready_out,
   output logic                       write_en_out,
   input  logic                       ack_in,
   output logic [BANK_ADDR_WIDTH-1:0] row_addr_out,
   output logic [COL_ADDR_WIDTH-1:0]  col_addr_out,
   output logic [TX_WIDTH-1:0]        partial_vec_out,
   output logic [BANK_ADDR_WIDTH-1:0] rows_out,
   output logic [COL_ADDR_WIDTH-1:0]  cols_out,
   output logic [15:0]                roll_count_out,
   output logic                       done_out,
   output logic                       error_out
);

   localparam int NW = GRID_WIDTH / TX_WIDTH;
   localparam int WW = $clog2(NW + 1);
   localparam int RW = BANK_ADDR_WIDTH + 1;
   localparam logic [WW-1:0] NW_W      = WW'(NW);
   localparam logic [WW-1:0] LAST_WORD = WW'(NW - 1);
   localparam logic [COL_ADDR_WIDTH-1:0] MAX_CELLS =
      COL_ADDR_WIDTH'(GRID_WIDTH - 2);
   localparam logic [COL_ADDR_WIDTH-1:0] ONE_C = COL_ADDR_WIDTH'(1);

   ld_state_t                 r_state, w_state_nx;
   logic [RW-1:0]             r_rows, w_rows_nx;
   logic [COL_ADDR_WIDTH-1:0] r_cols, w_cols_nx;
   logic [COL_ADDR_WIDTH-1:0] r_col, w_col_nx;
   logic [WW-1:0]             r_word, w_word_nx;
   logic                      r_eor, w_eor_nx;
   logic                      r_eof, w_eof_nx;

   logic                      w_start;
   logic                      w_accept;
   logic                      w_is_at;
   logic                      w_is_cell;
   logic                      w_is_lf;
   logic                      w_is_cr;
   logic                      w_bad;
   logic                      w_end_row;
   logic                      w_cell_err;
   logic                      w_len_err;
   logic                      w_push;
   logic                      w_clear;
   logic                      w_flush;
   logic                      w_row_done;
   logic [COL_ADDR_WIDTH-1:0] w_row_len;
   logic [TX_WIDTH-1:0]       w_acc_word;
   logic                      w_empty;
   logic                      w_word_full;

   assign w_start   = start_in && ((r_state == LD_IDLE) ||
                                   (r_state == LD_DONE) ||
                                   (r_state == LD_ERR));
   assign w_accept  = (r_state == LD_FILL) && char_valid_in;
   assign w_is_at   = (char_in == CH_AT);
   assign w_is_cell = w_is_at || (char_in == CH_DOT);
   assign w_is_lf   = (char_in == CH_LF);
   assign w_is_cr   = (char_in == CH_CR);
   assign w_bad     = !(w_is_cell || w_is_lf || w_is_cr);

   // eof on a cell or CR closes the row exactly like a newline
   assign w_end_row = w_is_lf || (eof_in && (w_is_cell || w_is_cr));
   assign w_row_len = w_is_cell ? r_col + ONE_C : r_col;

   // Overlong row, or a new row when every bank row is already used
   assign w_cell_err = w_is_cell &&
                       ((r_col == MAX_CELLS) || r_rows[RW-1]);
   assign w_len_err  = (w_row_len != '0) && (r_rows != '0) &&
                       (w_row_len != r_cols);
   assign w_push     = w_accept && w_is_cell && !w_cell_err;

   aoc4_word_packer #(
      .TX_WIDTH (TX_WIDTH)
   ) u_packer (
      .i_clk       (clock),
      .i_rst_n     (reset),
      .i_clear     (w_clear),
      .i_push      (w_push),
      .i_bit       (w_is_at),
      .i_flush     (w_flush),
      .o_word      (w_acc_word),
      .o_empty     (w_empty),
      .o_word_full (w_word_full)
   );

   // Next-state and datapath update for the load sequence
   always_comb begin
      w_state_nx = r_state;
      w_rows_nx  = r_rows;
      w_cols_nx  = r_cols;
      w_col_nx   = r_col;
      w_word_nx  = r_word;
      w_eor_nx   = r_eor;
      w_eof_nx   = r_eof;
      w_clear    = 1'b0;
      w_flush    = 1'b0;
      w_row_done = 1'b0;
      unique case (r_state)
         LD_IDLE, LD_DONE, LD_ERR: begin
            if (w_start) begin
               w_state_nx = LD_FILL;
               w_rows_nx  = '0;
               w_cols_nx  = '0;
               w_col_nx   = '0;
               w_word_nx  = '0;
               w_eor_nx   = 1'b0;
               w_eof_nx   = 1'b0;
               w_clear    = 1'b1;
            end
         end
         LD_FILL: begin
            if (w_accept) begin
               if (w_bad || w_cell_err) begin
                  w_state_nx = LD_ERR;
               end else begin
                  if (w_is_cell) begin
                     w_col_nx = w_row_len;
                  end
                  if (w_end_row) begin
                     if (w_row_len == '0) begin
                        if (eof_in) begin
                           w_state_nx = LD_DONE;
                        end
                     end else if (w_len_err) begin
                        w_state_nx = LD_ERR;
                     end else begin
                        w_eor_nx = 1'b1;
                        w_eof_nx = eof_in;
                        if (r_rows == '0) begin
                           w_cols_nx = w_row_len;
                        end
                        if (w_is_cell || !w_empty) begin
                           w_state_nx = LD_WRITE;
                        end else if (r_word < NW_W) begin
                           w_state_nx = LD_PAD;
                        end else begin
                           w_row_done = 1'b1;
                        end
                     end
                  end else if (w_word_full) begin
                     w_state_nx = LD_WRITE;
                  end
               end
            end
         end
         LD_WRITE: begin
            if (ack_in) begin
               w_flush = 1'b1;
               if (r_eor && (r_word == LAST_WORD)) begin
                  w_row_done = 1'b1;
               end else begin
                  w_word_nx  = r_word + WW'(1);
                  w_state_nx = r_eor ? LD_PAD : LD_FILL;
               end
            end
         end
         LD_PAD: begin
            if (ack_in) begin
               if (r_word == LAST_WORD) begin
                  w_row_done = 1'b1;
               end else begin
                  w_word_nx = r_word + WW'(1);
               end
            end
         end
         default: begin
            w_state_nx = LD_IDLE;
         end
      endcase
      if (w_row_done) begin
         w_rows_nx  = r_rows + RW'(1);
         w_col_nx   = '0;
         w_word_nx  = '0;
         w_eor_nx   = 1'b0;
         w_clear    = 1'b1;
         w_state_nx = w_eof_nx ? LD_DONE : LD_FILL;
      end
   end

   // State and counter registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= LD_IDLE;
         r_rows  <= '0;
         r_cols  <= '0;
         r_col   <= '0;
         r_word  <= '0;
         r_eor   <= 1'b0;
         r_eof   <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_rows  <= w_rows_nx;
         r_cols  <= w_cols_nx;
         r_col   <= w_col_nx;
         r_word  <= w_word_nx;
         r_eor   <= w_eor_nx;
         r_eof   <= w_eof_nx;
      end
   end

`ifdef AOC4_LOADER_COUNT_EN
   logic [15:0] r_roll;

   // Saturating count of accepted roll cells
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_roll <= '0;
      end else if (w_start) begin
         r_roll <= '0;
      end else if (w_push && w_is_at && (r_roll != ROLL_MAX)) begin
         r_roll <= r_roll + 16'd1;
      end
   end

   assign roll_count_out = r_roll;
`else
   assign roll_count_out = '0;
`endif

   assign char_ready_out  = (r_state == LD_FILL);
   assign write_en_out    = (r_state == LD_WRITE) ||
                            (r_state == LD_PAD);
   assign row_addr_out    = r_rows[BANK_ADDR_WIDTH-1:0];
   assign col_addr_out    = COL_ADDR_WIDTH'(r_word) *
                            COL_ADDR_WIDTH'(TX_WIDTH);
   assign partial_vec_out = (r_state == LD_WRITE) ? w_acc_word : '0;
   assign rows_out        = r_rows[BANK_ADDR_WIDTH-1:0];
   assign cols_out        = r_cols;
   assign done_out        = (r_state == LD_DONE);
   assign error_out       = (r_state == LD_ERR);

endmodule

// File: tb/tb_aoc4_grid_loader.sv
// tb_aoc4_grid_loader: directed streams with a write scoreboard
// for the day-4 grid loader.
module tb_aoc4_grid_loader;

   localparam int TXW = 32;
   localparam int GW  = 160;
   localparam int AW  = 8;
   localparam int CW  = 8;
   localparam int NW  = GW / TXW;
`ifdef AOC4_LOADER_COUNT_EN
   localparam bit CNT = 1'b1;
`else
   localparam bit CNT = 1'b0;
`endif

   logic           clock = 1'b0;
   logic           reset = 1'b0;
   logic           start_in = 1'b0;
   logic           char_valid_in = 1'b0;
   logic [7:0]     char_in = 8'h00;
   logic           eof_in = 1'b0;
   logic           ack_in = 1'b0;
   logic           char_ready_out;
   logic           write_en_out;
   logic [AW-1:0]  row_addr_out;
   logic [CW-1:0]  col_addr_out;
   logic [TXW-1:0] partial_vec_out;
   logic [AW-1:0]  rows_out;
   logic [CW-1:0]  cols_out;
   logic [15:0]    roll_count_out;
   logic           done_out;
   logic           error_out;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int             row;
      int             col;
      logic [TXW-1:0] data;
   } wr_t;

   wr_t sb[$];

   aoc4_grid_loader dut (
      .clock           (clock),
      .reset           (reset),
      .start_in        (start_in),
      .char_valid_in   (char_valid_in),
      .char_in         (char_in),
      .eof_in          (eof_in),
      .char_ready_out  (char_ready_out),
      .write_en_out    (write_en_out),
      .ack_in          (ack_in),
      .row_addr_out    (row_addr_out),
      .col_addr_out    (col_addr_out),
      .partial_vec_out (partial_vec_out),
      .rows_out        (rows_out),
      .cols_out        (cols_out),
      .roll_count_out  (roll_count_out),
      .done_out        (done_out),
      .error_out       (error_out)
   );

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push_wr(input int row, input int col,
                          input logic [TXW-1:0] data);
      wr_t w;
      w.row  = row;
      w.col  = col;
      w.data = data;
      sb.push_back(w);
   endtask

   task automatic expect_row(input int row, input string cells);
      logic [GW-1:0] v;
      v = '0;
      for (int c = 0; c < cells.len(); c++) begin
         if (cells[c] == 8'h40) v[c+1] = 1'b1;
      end
      for (int k = 0; k < NW; k++) begin
         push_wr(row, k * TXW, v[k*TXW +: TXW]);
      end
   endtask

   task automatic pulse_start();
      start_in = 1'b1;
      @(posedge clock); #1;
      start_in = 1'b0;
   endtask

   task automatic run_stream(input string s, input bit eof_last,
                             input int lat, input int err_idx,
                             input int abort_hold, input int budget);
      int ptr;
      int held;
      int cyc;
      int pend;
      bit err_exp;
      bit fin;
      ptr = 0; held = 0; cyc = 0; pend = -1;
      err_exp = 1'b0; fin = 1'b0;
      while (!fin) begin
         if (pend >= 0 && pend == err_idx) err_exp = 1'b1;
         chk("error_flag", error_out, err_exp);
         ack_in = 1'b0;
         if (write_en_out) begin
            chk("ready_low_in_write", char_ready_out, 0);
            if (sb.size() == 0) begin
               chk("write_expected", write_en_out, 0);
            end else begin
               chk("row_addr", row_addr_out, sb[0].row);
               chk("col_addr", col_addr_out, sb[0].col);
               chk("data", partial_vec_out, sb[0].data);
            end
            if (held >= lat) begin
               ack_in = 1'b1;
               held = 0;
               if (sb.size() != 0) void'(sb.pop_front());
            end else begin
               held++;
            end
            if (abort_hold > 0 && held >= abort_hold) fin = 1'b1;
         end else if (held != 0) begin
            chk("write_held_until_ack", write_en_out, 1);
            held = 0;
         end
         pend = -1;
         if (ptr < s.len() && !fin) begin
            char_valid_in = 1'b1;
            char_in = s[ptr];
            eof_in = eof_last && (ptr == s.len() - 1);
            if (char_ready_out) begin
               pend = ptr;
               ptr++;
            end
         end else begin
            char_valid_in = 1'b0;
            eof_in = 1'b0;
         end
         if (done_out || error_out) fin = 1'b1;
         cyc++;
         if (!fin && cyc >= budget) begin
            chk("stream_timeout", done_out || error_out, 1);
            fin = 1'b1;
         end
         if (!fin) begin
            @(posedge clock); #1;
         end
      end
      char_valid_in = 1'b0;
      eof_in = 1'b0;
      ack_in = 1'b0;
   endtask

   task automatic check_end(input string tag, input int rows,
                            input int cols, input int roll,
                            input bit done, input bit err);
      chk({tag, "_rows"}, rows_out, rows);
      chk({tag, "_cols"}, cols_out, cols);
      chk({tag, "_roll"}, roll_count_out, CNT ? roll : 0);
      chk({tag, "_done"}, done_out, done);
      chk({tag, "_error"}, error_out, err);
      chk({tag, "_sb_drained"}, sb.size(), 0);
   endtask

   initial begin
      string s40;

      repeat (3) @(posedge clock);
      #1;
      chk("rst_write_en", write_en_out, 0);
      chk("rst_ready", char_ready_out, 0);
      chk("rst_done", done_out, 0);
      chk("rst_error", error_out, 0);
      chk("rst_rows", rows_out, 0);
      chk("rst_cols", cols_out, 0);
      chk("rst_roll", roll_count_out, 0);
      chk("rst_row_addr", row_addr_out, 0);
      chk("rst_col_addr", col_addr_out, 0);
      chk("rst_data", partial_vec_out, 0);
      reset = 1'b1;
      @(posedge clock); #1;
      chk("idle_ready", char_ready_out, 0);
      pulse_start();
      chk("start_ready", char_ready_out, 1);

      // basic row, ack one cycle after request
      push_wr(0, 0, 32'h0000_0018);
      push_wr(0, 32, 32'h0);
      push_wr(0, 64, 32'h0);
      push_wr(0, 96, 32'h0);
      push_wr(0, 128, 32'h0);
      run_stream("..@@.\n", 1'b1, 1, -1, 0, 200);
      check_end("basic", 1, 5, 2, 1'b1, 1'b0);

      // same row, ack delayed three cycles
      pulse_start();
      chk("restart_done", done_out, 0);
      chk("restart_rows", rows_out, 0);
      chk("restart_ready", char_ready_out, 1);
      expect_row(0, "..@@.");
      run_stream("..@@.\n", 1'b1, 3, -1, 0, 300);
      check_end("stall", 1, 5, 2, 1'b1, 1'b0);

      // forty rolls straddling the first word boundary
      pulse_start();
      s40 = "";
      for (int i = 0; i < 40; i++) s40 = {s40, "@"};
      push_wr(0, 0, 32'hFFFF_FFFE);
      push_wr(0, 32, 32'h0000_01FF);
      push_wr(0, 64, 32'h0);
      push_wr(0, 96, 32'h0);
      push_wr(0, 128, 32'h0);
      run_stream({s40, "\n"}, 1'b1, 1, -1, 0, 400);
      check_end("forty", 1, 40, 40, 1'b1, 1'b0);

      // blank line, CR, and eof on a cell byte
      pulse_start();
      expect_row(0, "@.");
      expect_row(1, ".@");
      run_stream("\n@.\r\n.@", 1'b1, 0, -1, 0, 300);
      check_end("multi", 2, 2, 2, 1'b1, 1'b0);

      // mismatched row width
      pulse_start();
      expect_row(0, "@@");
      run_stream("@@\n@\n", 1'b0, 1, 4, 0, 300);
      check_end("width", 1, 2, 3, 1'b0, 1'b1);
      chk("width_ready", char_ready_out, 0);
      chk("width_write_en", write_en_out, 0);
      repeat (3) @(posedge clock);
      #1;
      chk("width_rows_frozen", rows_out, 1);
      chk("width_err_sticky", error_out, 1);

      // illegal byte, then start clears everything
      pulse_start();
      chk("clr_error", error_out, 0);
      chk("clr_rows", rows_out, 0);
      chk("clr_cols", cols_out, 0);
      chk("clr_roll", roll_count_out, 0);
      run_stream("@x", 1'b0, 1, 1, 0, 100);
      check_end("badchar", 0, 0, 1, 1'b0, 1'b1);
      pulse_start();
      chk("badchar_clr_error", error_out, 0);
      chk("badchar_clr_roll", roll_count_out, 0);
      chk("badchar_clr_ready", char_ready_out, 1);

      // asynchronous reset in the middle of a held write
      expect_row(0, "@@@");
      run_stream("@@@\n", 1'b0, 1000, -1, 3, 100);
      chk("hold_write_en", write_en_out, 1);
      #2;
      reset = 1'b0;
      #1;
      chk("arst_write_en", write_en_out, 0);
      chk("arst_ready", char_ready_out, 0);
      chk("arst_rows", rows_out, 0);
      chk("arst_col_addr", col_addr_out, 0);
      chk("arst_data", partial_vec_out, 0);
      chk("arst_done", done_out, 0);
      sb.delete();
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      chk("arst_idle_ready", char_ready_out, 0);
      pulse_start();
      chk("arst_start_ready", char_ready_out, 1);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
